// File: rtl/accumulate.sv
// Packet accumulator: sign-extends ARGW-bit terms, sums each last-delimited
// packet at RESW bits and emits one sum, term count and overflow flag per packet.
module accumulate #(
  parameter int ARGW = 8,
  parameter int RESW = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_stb,
  input  logic [ARGW-1:0] arg_dat,
  input  logic            arg_lst,
  output logic            arg_rdy,
  output logic            res_stb,
  output logic [RESW-1:0] res_dat,
  output logic [CNTW-1:0] res_cnt,
  output logic            res_ovf,
  input  logic            res_rdy
);

  generate
    if (RESW < ARGW) begin : g_width_check
      $error("accumulate: RESW (%0d) must be >= ARGW (%0d)", RESW, ARGW);
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RESW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;
  logic            r_res_stb;
  logic [RESW-1:0] r_res_dat;
  logic [CNTW-1:0] r_res_cnt;
  logic            r_res_ovf;

  logic [RESW-1:0] w_ext;
  logic [RESW-1:0] w_sum;
  logic [CNTW-1:0] w_cnt_inc;
  logic            w_add_ovf;
  logic            w_arg_rdy;
  logic            w_accept;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_arg_rdy = ~r_res_stb | res_rdy;
  assign w_accept  = arg_stb & w_arg_rdy;
  assign w_ext     = RESW'($signed(arg_dat));
  assign w_sum     = r_acc + w_ext;
  assign w_add_ovf = add_ovf(r_acc[RESW-1], w_ext[RESW-1], w_sum[RESW-1]);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNTW'(1);

  assign arg_rdy = w_arg_rdy;
  assign res_stb = r_res_stb;
  assign res_dat = r_res_dat;
  assign res_cnt = r_res_cnt;
  assign res_ovf = r_res_ovf;

  // Packet phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase transitions: a non-last beat opens a packet, a last beat closes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !arg_lst) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_accept && arg_lst) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Running packet sum, count and sticky overflow; cleared when a packet closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= {RESW{1'b0}};
      r_cnt <= {CNTW{1'b0}};
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (arg_lst) begin
        r_acc <= {RESW{1'b0}};
        r_cnt <= {CNTW{1'b0}};
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_add_ovf;
      end
    end
  end

  // Result register; a last beat accepted during consumption reloads without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_stb <= 1'b0;
      r_res_dat <= {RESW{1'b0}};
      r_res_cnt <= {CNTW{1'b0}};
      r_res_ovf <= 1'b0;
    end else if (w_accept && arg_lst) begin
      r_res_stb <= 1'b1;
      r_res_dat <= w_sum;
      r_res_cnt <= w_cnt_inc;
      r_res_ovf <= r_ovf | w_add_ovf;
    end else if (res_rdy) begin
      r_res_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// Self-checking bench for accumulate: directed vector table, hand-written
// corner sequences and a randomized run against a packet-level reference model.
module tb_accumulate;
  localparam int ARGW = 8;
  localparam int RESW = 12;
  localparam int CNTW = 4;
  localparam int MAXV = 2 ** (RESW - 1) - 1;
  localparam int MINV = -(2 ** (RESW - 1));
  localparam int CMAX = 2 ** CNTW - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            arg_stb = 1'b0;
  logic [ARGW-1:0] arg_dat = '0;
  logic            arg_lst = 1'b0;
  logic            arg_rdy;
  logic            res_stb;
  logic [RESW-1:0] res_dat;
  logic [CNTW-1:0] res_cnt;
  logic            res_ovf;
  logic            res_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  accumulate #(.ARGW(ARGW), .RESW(RESW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_lst(arg_lst), .arg_rdy(arg_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_cnt(res_cnt), .res_ovf(res_ovf),
    .res_rdy(res_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            stb;
    logic [ARGW-1:0] dat;
    logic            lst;
    logic            rdy;
    logic            e_stb;
    logic [RESW-1:0] e_dat;
    logic [CNTW-1:0] e_cnt;
    logic            e_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [ARGW-1:0] d, input logic l, input logic r);
    arg_stb = s;
    arg_dat = d;
    arg_lst = l;
    res_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string nm, input logic s, input logic [RESW-1:0] d,
                         input logic [CNTW-1:0] c, input logic o);
    chk({nm, ".stb"}, 32'(res_stb), 32'(s));
    chk({nm, ".dat"}, 32'(res_dat), 32'(d));
    chk({nm, ".cnt"}, 32'(res_cnt), 32'(c));
    chk({nm, ".ovf"}, 32'(res_ovf), 32'(o));
  endtask

  // Reference model state: visible result plus open-packet bookkeeping.
  logic            m_stb;
  logic [RESW-1:0] m_dat;
  int              m_cnt;
  logic            m_ovf;
  int              p_acc;
  int              p_cnt;
  logic            p_ovf;

  task automatic model_clear();
    m_stb = 1'b0; m_dat = '0; m_cnt = 0; m_ovf = 1'b0;
    p_acc = 0; p_cnt = 0; p_ovf = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [ARGW-1:0] d, input logic l, input logic r);
    int t;
    int raw;
    int w;
    logic o;
    logic acc_ok;
    acc_ok = s && (!m_stb || r);
    if (acc_ok) begin
      t   = int'($signed(d));
      raw = p_acc + t;
      o   = (raw > MAXV) || (raw < MINV);
      w   = raw;
      if (w > MAXV) w = w - 2 ** RESW;
      if (w < MINV) w = w + 2 ** RESW;
      if (l) begin
        m_stb = 1'b1;
        m_dat = RESW'(w);
        m_cnt = (p_cnt + 1 > CMAX) ? CMAX : p_cnt + 1;
        m_ovf = p_ovf | o;
        p_acc = 0; p_cnt = 0; p_ovf = 1'b0;
      end else begin
        p_acc = w;
        p_cnt = p_cnt + 1;
        p_ovf = p_ovf | o;
      end
    end else if (r) begin
      m_stb = 1'b0;
    end
    if (acc_ok && !l && r) m_stb = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd5,   1'b0, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 8'hFD,  1'b0, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 8'd10,  1'b1, 1'b1, 1'b1, 12'd12,  4'd3, 1'b0};
    tbl[3] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 12'd12,  4'd3, 1'b0};
    tbl[4] = '{1'b1, 8'h80,  1'b1, 1'b1, 1'b1, 12'hF80, 4'd1, 1'b0};
    tbl[5] = '{1'b1, 8'h7F,  1'b1, 1'b1, 1'b1, 12'h07F, 4'd1, 1'b0};
    tbl[6] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 12'h07F, 4'd1, 1'b0};

    drive(1'b0, 8'd0, 1'b0, 1'b1);
    repeat (2) tick();
    chk_res("reset", 1'b0, 12'h000, 4'd0, 1'b0);
    chk("reset.arg_rdy", 32'(arg_rdy), 32'd1);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].stb, tbl[i].dat, tbl[i].lst, tbl[i].rdy);
      tick();
      chk_res($sformatf("vec%0d", i), tbl[i].e_stb, tbl[i].e_dat, tbl[i].e_cnt, tbl[i].e_ovf);
    end

    // 17 beats of 127: wraps on the last add, count saturates at 15.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'd127, (i == 16), 1'b1);
      tick();
    end
    chk_res("sat17", 1'b1, 12'h86F, 4'd15, 1'b1);
    drive(1'b1, 8'd1, 1'b1, 1'b1);
    tick();
    chk_res("after_sat", 1'b1, 12'h001, 4'd1, 1'b0);

    // Backpressure: hold a result for 5 cycles while beats are offered.
    drive(1'b1, 8'd9, 1'b1, 1'b1);
    tick();
    chk_res("bp_load", 1'b1, 12'd9, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'd55, i[0], 1'b0);
      #1;
      chk("bp.arg_rdy", 32'(arg_rdy), 32'd0);
      tick();
      chk_res("bp_hold", 1'b1, 12'd9, 4'd1, 1'b0);
    end
    drive(1'b1, 8'd4, 1'b1, 1'b1);
    #1;
    chk("bp_release.arg_rdy", 32'(arg_rdy), 32'd1);
    tick();
    chk_res("bp_release", 1'b1, 12'd4, 4'd1, 1'b0);

    // Asynchronous reset in the middle of a packet.
    drive(1'b1, 8'd20, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'd30, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_res("async_rst", 1'b0, 12'h000, 4'd0, 1'b0);
    #1 rst = 1'b1;
    tick();
    drive(1'b1, 8'd7, 1'b1, 1'b1);
    tick();
    chk_res("post_rst", 1'b1, 12'd7, 4'd1, 1'b0);

    // Randomized run against the packet-level model.
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    model_clear();
    for (int i = 0; i < 600; i++) begin
      logic s;
      logic l;
      logic r;
      logic [ARGW-1:0] d;
      s = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 3) != 0);
      d = ARGW'($urandom);
      drive(s, d, l, r);
      #1;
      chk("rnd.arg_rdy", 32'(arg_rdy), 32'(!m_stb || r));
      model_step(s, d, l, r);
      tick();
      chk_res("rnd", m_stb, m_dat, CNTW'(m_cnt), m_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
